rf_writeback_unit: RTL
======================

Name: rf_writeback_unit

Overview:
- Writer side of the integer register file: the final pipeline stage of the RV32I core.
- Owns the MEM/WB pipeline register and waits for data-memory load responses.
- Sign/zero-extends load data and drives the register-file write port (write_en/write_addr/write_value).
- Exports a forwarding tap and a load-pending indication so decode can bypass or stall.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
REG_ADDR_W, 5, register index width.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
mem_valid  in  1  MEM stage presents an instruction.
mem_ready  out  1  unit accepts the instruction this cycle.
mem_rd_we  in  1  instruction writes rd.
mem_rd_addr  in  5  destination register index.
mem_is_load  in  1  result comes from data memory.
mem_funct3  in  3  load type: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
mem_addr_lo  in  2  byte offset, i.e. load address bits [1:0].
mem_alu_result  in  32  result for non-load instructions.
dmem_rvalid  in  1  load response valid (single-cycle pulse).
dmem_rdata  in  32  raw aligned load word.
write_en  out  1  register-file write enable.
write_addr  out  5  register-file write index.
write_value  out  32  register-file write data.
fwd_valid  out  1  forwarding tap valid.
fwd_addr  out  5  forwarding index.
fwd_value  out  32  forwarding data.
load_pending  out  1  a load is awaiting its response.
load_pending_rd  out  5  rd of the pending load; 0 when none is pending.
protocol_err  out  1  sticky; set by an unexpected dmem_rvalid.

Behaviour:
- Clock and reset: clock clk; reset reset, synchronous, active-high.
- Reset state: EMPTY; result register 0; protocol_err 0. Every output is 0 except mem_ready, which is 1.
- State machine, three states:
  - EMPTY: mem_ready=1.
    - Accept of a non-load -> FULL; the result register captures mem_alu_result.
    - Accept of a load -> WAIT_LOAD.
    - rd_addr, rd_we, funct3 and addr_lo are captured on every accept.
  - WAIT_LOAD: mem_ready=0; load_pending=1; load_pending_rd=captured rd.
    - On dmem_rvalid, the result register captures the extended data -> FULL.
    - Any number of wait cycles is allowed.
  - FULL: the result is committed this cycle; mem_ready=1.
    - Same-cycle accept -> FULL or WAIT_LOAD, as above (back-to-back, no bubble).
    - Otherwise -> EMPTY.
- Accept condition: mem_valid && mem_ready.
- Latency:
  - Non-load: write in the cycle after accept; sustains 1 instruction per cycle.
  - Load: write in the cycle after dmem_rvalid.
- Write port:
  - write_en = (state==FULL) && rd_we && (rd_addr!=0).
  - write_addr and write_value are driven from the captured fields only when write_en=1; otherwise they are 0.
  - rd=x0 never produces a write.
- Forwarding tap: fwd_valid/fwd_addr/fwd_value are identical to write_en/write_addr/write_value.
- Load extension:
  - LB/LBU select byte dmem_rdata[8*addr_lo +: 8].
  - LH/LHU select half dmem_rdata[16*addr_lo[1] +: 16]; addr_lo[0] is ignored.
  - LW ignores addr_lo.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Undefined funct3 (3, 6, 7) passes dmem_rdata unchanged.
- dmem_rvalid outside WAIT_LOAD: ignored for data and sets protocol_err, which holds until reset.
- Simultaneous events:
  - dmem_rvalid and mem_valid in the same WAIT_LOAD cycle: the response is taken; the instruction is not accepted (mem_ready=0).
- Reset mid-load: state returns to EMPTY; the pending load is dropped; no write occurs.

Test Plan:
- Reset, then accept ALU op rd=5, result 0x1234_5678 -> next cycle write_en=1, addr=5, value=0x1234_5678, fwd_valid=1; the cycle after, write_en=0.
- Three back-to-back ALU ops rd=1,2,3 with mem_valid held high -> mem_ready stays 1; writes on 3 consecutive cycles in order.
- LB addr_lo=3, rdata=0x80FF_0000 after 4 wait cycles:
  - load_pending=1 and load_pending_rd=rd during the wait; mem_ready=0.
  - The write occurs the cycle after rvalid, value 0xFFFF_FF80.
  - The same test with LBU must write 0x0000_0080.
- LH addr_lo=2, rdata=0x9ABC_0001 -> 0xFFFF_9ABC. LHU -> 0x0000_9ABC. LW addr_lo=1 -> 0x9ABC_0001.
- ALU op with rd=0, value 0xDEAD_BEEF -> write_en=0 and fwd_valid=0 throughout. A later stray dmem_rvalid in EMPTY -> protocol_err=1 until reset.
- Load accepted, reset asserted during WAIT_LOAD -> next cycle: state EMPTY, load_pending=0, mem_ready=1; no write on any later cycle.

Source files
------------

// File: rtl/rf_writeback_unit.sv
// rtl/rf_writeback_unit.sv - RV32I writeback stage: MEM/WB register, load extension, register-file write port
//
// Purpose:
//   Final pipeline stage of the RV32I core. Holds the MEM/WB pipeline register,
//   waits for data-memory load responses, sign/zero-extends load data and
//   drives the register-file write port. A forwarding tap mirrors the write
//   port, and load_pending/load_pending_rd let decode stall on load-use hazards.
//
// Ports:
//   clk, reset                    clock; synchronous active-high reset
//   mem_valid / mem_ready         MEM-stage handshake (accept = valid && ready)
//   mem_rd_we, mem_rd_addr        destination write enable / index
//   mem_is_load, mem_funct3       load flag and load type
//   mem_addr_lo                   load byte offset (address bits [1:0])
//   mem_alu_result                result for non-load instructions
//   dmem_rvalid, dmem_rdata       load response pulse and raw aligned word
//   write_en/_addr/_value         register-file write port
//   fwd_valid/_addr/_value        forwarding tap (identical to write port)
//   load_pending, load_pending_rd load in flight and its rd (0 when idle)
//   protocol_err                  sticky flag: dmem_rvalid outside WAIT_LOAD

module rf_writeback_unit #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic                  mem_rd_we,
  input  logic [REG_ADDR_W-1:0] mem_rd_addr,
  input  logic                  mem_is_load,
  input  logic [2:0]            mem_funct3,
  input  logic [1:0]            mem_addr_lo,
  input  logic [XLEN-1:0]       mem_alu_result,
  input  logic                  dmem_rvalid,
  input  logic [XLEN-1:0]       dmem_rdata,
  output logic                  write_en,
  output logic [REG_ADDR_W-1:0] write_addr,
  output logic [XLEN-1:0]       write_value,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_addr,
  output logic [XLEN-1:0]       fwd_value,
  output logic                  load_pending,
  output logic [REG_ADDR_W-1:0] load_pending_rd,
  output logic                  protocol_err
);

  typedef enum logic [1:0] {
    ST_EMPTY     = 2'd0,
    ST_WAIT_LOAD = 2'd1,
    ST_FULL      = 2'd2
  } state_t;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [REG_ADDR_W-1:0]   r_rd_addr;
  logic                    r_rd_we;
  logic [2:0]              r_funct3;
  logic [1:0]              r_addr_lo;
  logic [XLEN-1:0]         r_result;
  logic                    r_protocol_err;

  logic                    w_mem_ready;
  logic                    w_accept;
  logic                    w_take_resp;
  logic                    w_write_en;
  logic [7:0]              w_byte;
  logic [15:0]             w_half;
  logic [XLEN-1:0]         w_load_ext;

  // Only WAIT_LOAD blocks; FULL commits and accepts in the same cycle.
  assign w_mem_ready = (r_state != ST_WAIT_LOAD);
  assign w_accept    = mem_valid && w_mem_ready;
  assign w_take_resp = (r_state == ST_WAIT_LOAD) && dmem_rvalid;

  // Extension uses the funct3/offset captured at accept, not the live MEM inputs.
  always_comb begin
    w_byte     = dmem_rdata[8*r_addr_lo +: 8];
    w_half     = dmem_rdata[16*r_addr_lo[1] +: 16];
    w_load_ext = dmem_rdata;
    case (r_funct3)
      F3_LB:   w_load_ext = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_LH:   w_load_ext = {{(XLEN-16){w_half[15]}}, w_half};
      F3_LW:   w_load_ext = dmem_rdata;
      F3_LBU:  w_load_ext = {{(XLEN-8){1'b0}}, w_byte};
      F3_LHU:  w_load_ext = {{(XLEN-16){1'b0}}, w_half};
      default: w_load_ext = dmem_rdata;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_EMPTY, ST_FULL: begin
        if (w_accept) begin
          w_state_next = mem_is_load ? ST_WAIT_LOAD : ST_FULL;
        end else begin
          w_state_next = ST_EMPTY;
        end
      end
      ST_WAIT_LOAD: begin
        if (dmem_rvalid) begin
          w_state_next = ST_FULL;
        end
      end
      default: w_state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_addr      <= '0;
      r_rd_we        <= 1'b0;
      r_funct3       <= '0;
      r_addr_lo      <= '0;
      r_result       <= '0;
      r_protocol_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rd_addr <= mem_rd_addr;
        r_rd_we   <= mem_rd_we;
        r_funct3  <= mem_funct3;
        r_addr_lo <= mem_addr_lo;
        if (!mem_is_load) begin
          r_result <= mem_alu_result;
        end
      end
      if (w_take_resp) begin
        r_result <= w_load_ext;
      end
      // A response with no load outstanding is dropped but remembered.
      if (dmem_rvalid && (r_state != ST_WAIT_LOAD)) begin
        r_protocol_err <= 1'b1;
      end
    end
  end

  assign w_write_en = (r_state == ST_FULL) && r_rd_we && (r_rd_addr != '0);

  assign mem_ready       = w_mem_ready;
  assign write_en        = w_write_en;
  assign write_addr      = w_write_en ? r_rd_addr : '0;
  assign write_value     = w_write_en ? r_result : '0;
  assign fwd_valid       = w_write_en;
  assign fwd_addr        = w_write_en ? r_rd_addr : '0;
  assign fwd_value       = w_write_en ? r_result : '0;
  assign load_pending    = (r_state == ST_WAIT_LOAD);
  assign load_pending_rd = (r_state == ST_WAIT_LOAD) ? r_rd_addr : '0;
  assign protocol_err    = r_protocol_err;

endmodule
